// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// registered {remainder, quotient} result with ready/busy handshake and annul.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic                sgn_q, sgn_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   step_rem, step_quo;

  // Trial subtraction on the shifted partial remainder; the extra top bit is the borrow.
  assign trial = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;
    step_rem = trial[DATA_W] ? {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]} : trial[DATA_W-1:0];
    step_quo = {dvd_q[DATA_W-2:0], ~trial[DATA_W]};

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
            dsr_d   = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
            sgn_d   = signed_div_i;
            s1_d    = opdata1_i[DATA_W-1];
            s2_d    = opdata2_i[DATA_W-1];
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            // Remainder follows the dividend sign; quotient is negative when signs differ.
            result_d = {(sgn_q && s1_q) ? -step_rem : step_rem,
                        (sgn_q && (s1_q ^ s2_q)) ? -step_quo : step_quo};
          end
        end
      end
      S_END: begin
        if (!start_i) begin
          state_d  = S_IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_BYZERO) || (state_d == S_ON);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule
